reg_access_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single port of the register bank between NUM_REQ requesters, e.g. host command decoder, sync monitor and channel manager.
- Latches the winning request and drives the bank's readEnable/writeEnable/address/writeData/writeAdmin for exactly one cycle.
- Waits for readData or writeAck and returns the result to the winner with a one-cycle done pulse.
- Sits between the requesters and the register bank, one instance per bank.

---
 rtl/reg_access_arbiter.sv | 179 +++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: round-robin arbiter and sequencer for the single port of a
// register bank. It grants one requester at a time, issues a one-cycle
// read or write, waits for readData/writeAck, and returns a done pulse.
// Optional feature macro: REG_ARB_ADMIN_EN. When it is defined, the
// ADMIN_MASK parameter selects which requesters write with writeAdmin set.
module reg_access_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8
`ifdef REG_ARB_ADMIN_EN
  , parameter logic [NUM_REQ-1:0] ADMIN_MASK = NUM_REQ'(1)
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      readEnable,
  output logic                      writeEnable,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         writeData,
  output logic                      writeAdmin,
  input  logic                      writeAck,
  input  logic [DATA_W-1:0]         readData
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_timeout;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  int                 w_idx;

  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_win;
  logic               r_lat_we;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_busy;
  logic               r_re;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
`ifdef REG_ARB_ADMIN_EN
  logic               r_wadm;
`endif

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_idx);
      end
    end
  end

  // Next-state decode; a write still unacknowledged on the last counted cycle times out.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!r_lat_we || writeAck) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Registered outputs, request latch, rr pointer and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr     <= '0;
      r_win    <= '0;
      r_lat_we <= 1'b0;
      r_cnt    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
`ifdef REG_ARB_ADMIN_EN
      r_wadm   <= 1'b0;
`endif
    end else begin
      r_re   <= 1'b0;
      r_we   <= 1'b0;
      r_done <= '0;
      r_err  <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
`ifdef REG_ARB_ADMIN_EN
      r_wadm <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            // The bank-side registers double as the request latch.
            r_win    <= w_win;
            r_lat_we <= req_we[w_win];
            r_re     <= ~req_we[w_win];
            r_we     <= req_we[w_win];
            r_addr   <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_wdata  <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
`ifdef REG_ARB_ADMIN_EN
            r_wadm   <= req_we[w_win] & ADMIN_MASK[w_win];
`endif
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          r_rr  <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
        end
        S_WAIT: begin
          if (!r_lat_we) begin
            r_rdata       <= readData;
            r_done[r_win] <= 1'b1;
          end else if (writeAck || w_timeout) begin
            r_err         <= w_timeout;
            r_done[r_win] <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done        = r_done;
  assign err         = r_err;
  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign readEnable  = r_re;
  assign writeEnable = r_we;
  assign address     = r_addr;
  assign writeData   = r_wdata;
`ifdef REG_ARB_ADMIN_EN
  assign writeAdmin  = r_wadm;
`else
  assign writeAdmin  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed testbench for reg_access_arbiter (NUM_REQ=3, ACK_TIMEOUT=8) with a
// small register-bank model providing registered readData and writeAck.
module tb_reg_access_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
`ifdef REG_ARB_ADMIN_EN
  localparam logic EXP_ADM0 = 1'b1;
`else
  localparam logic EXP_ADM0 = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        req_we = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      readEnable;
  logic                      writeEnable;
  logic [ADDR_W-1:0]         address;
  logic [DATA_W-1:0]         writeData;
  logic                      writeAdmin;
  logic                      writeAck;
  logic [DATA_W-1:0]         readData;

  logic [DATA_W-1:0] rd_val = '0;
  logic              ack_en = 1'b1;
  int                both_cnt = 0;
  int                onehot_bad = 0;
  int                checks = 0;
  int                errors = 0;

  reg_access_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .readEnable(readEnable), .writeEnable(writeEnable), .address(address),
    .writeData(writeData), .writeAdmin(writeAdmin), .writeAck(writeAck),
    .readData(readData)
  );

  always #5 clk = ~clk;

  // Bank model: readData registered on readEnable, writeAck follows writeEnable by one cycle.
  always @(posedge clk) begin
    if (reset) begin
      readData <= '0;
      writeAck <= 1'b0;
    end else begin
      if (readEnable) readData <= rd_val;
      writeAck <= writeEnable & ack_en;
    end
  end

  // Invariant monitor on the inactive edge.
  always @(negedge clk) begin
    if (readEnable && writeEnable) both_cnt <= both_cnt + 1;
    if (!$onehot0(done)) onehot_bad <= onehot_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_we[i] = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    do_reset();
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rst_done: got %b expected 000", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if ({readEnable, writeEnable, writeAdmin} !== 3'b000) begin errors++; $display("FAIL rst_enables: got %b expected 000", {readEnable, writeEnable, writeAdmin}); end
    checks++; if (address !== 4'h0) begin errors++; $display("FAIL rst_address: got %h expected 0", address); end
    checks++; if (writeData !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", writeData); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (readEnable || writeEnable || busy || (done != 0)) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL idle_activity: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 4'd3, 32'h0);
    rd_val = 32'hDEADBEEF;
    req = 3'b001;
    tick();
    checks++; if ({readEnable, writeEnable} !== 2'b10) begin errors++; $display("FAIL rd_enable: got %b expected 10", {readEnable, writeEnable}); end
    checks++; if (address !== 4'd3) begin errors++; $display("FAIL rd_address: got %h expected 3", address); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b expected 1", busy); end
    tick();
    checks++; if (readEnable !== 1'b0) begin errors++; $display("FAIL rd_one_cycle: got %b expected 0", readEnable); end
    tick();
    checks++; if (done !== 3'b001) begin errors++; $display("FAIL rd_done: got %b expected 001", done); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", err); end
    req = 3'b000;
    tick();
    checks++; if ({done, busy} !== 4'b0000) begin errors++; $display("FAIL rd_after: got %b expected 0000", {done, busy}); end
  endtask

  task automatic test_write_ack();
    ack_en = 1'b1;
    set_req(1, 1'b1, 4'd5, 32'h1);
    req = 3'b010;
    tick();
    checks++; if ({readEnable, writeEnable} !== 2'b01) begin errors++; $display("FAIL wr_enable: got %b expected 01", {readEnable, writeEnable}); end
    checks++; if (address !== 4'd5) begin errors++; $display("FAIL wr_address: got %h expected 5", address); end
    checks++; if (writeData !== 32'h1) begin errors++; $display("FAIL wr_wdata: got %h expected 1", writeData); end
    checks++; if (writeAdmin !== 1'b0) begin errors++; $display("FAIL wr_admin_r1: got %b expected 0", writeAdmin); end
    tick();
    checks++; if ({writeEnable, writeAck} !== 2'b01) begin errors++; $display("FAIL wr_ack_phase: got %b expected 01", {writeEnable, writeAck}); end
    tick();
    checks++; if (done !== 3'b010) begin errors++; $display("FAIL wr_done: got %b expected 010", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", err); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rdata_hold: got %h expected deadbeef", rdata); end
    checks++; if (writeAck !== 1'b0) begin errors++; $display("FAIL wr_ack_cleared: got %b expected 0", writeAck); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_fairness();
    int exp;
    do_reset();
    rd_val = 32'hCAFE0000;
    set_req(0, 1'b0, 4'd1, 32'h0);
    set_req(1, 1'b0, 4'd2, 32'h0);
    set_req(2, 1'b0, 4'd3, 32'h0);
    req = 3'b111;
    for (int n = 0; n < 12; n++) begin
      exp = n % 3;
      tick();
      checks++; if ({readEnable, address} !== {1'b1, 4'(exp + 1)}) begin errors++; $display("FAIL rr_issue%0d: got en=%b addr=%h expected en=1 addr=%h", n, readEnable, address, exp + 1); end
      tick();
      tick();
      checks++; if (done !== 3'(1 << exp)) begin errors++; $display("FAIL rr_done%0d: got %b expected %b", n, done, 3'(1 << exp)); end
      if (n == 11) req = 3'b000;
      tick();
      checks++; if ({readEnable, done} !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: got %b expected 0000", n, {readEnable, done}); end
    end
  endtask

  task automatic test_timeout();
    int early;
    ack_en = 1'b0;
    set_req(2, 1'b1, 4'd7, 32'hAA);
    req = 3'b100;
    tick();
    checks++; if ({writeEnable, address, writeAdmin} !== {1'b1, 4'd7, 1'b0}) begin errors++; $display("FAIL to_issue: got we=%b addr=%h adm=%b expected 1 7 0", writeEnable, address, writeAdmin); end
    tick();
    early = 0;
    for (int i = 3; i <= 9; i++) begin
      tick();
      if (done != 0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early_done: got %0d expected 0", early); end
    tick();
    checks++; if (done !== 3'b100) begin errors++; $display("FAIL to_done: got %b expected 100", done); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err); end
    req = 3'b000;
    tick();
    checks++; if ({done, err, busy} !== 5'b00000) begin errors++; $display("FAIL to_after: got %b expected 00000", {done, err, busy}); end
    ack_en = 1'b1;
    set_req(0, 1'b1, 4'd9, 32'h55);
    req = 3'b001;
    tick();
    checks++; if ({writeEnable, writeData} !== {1'b1, 32'h55}) begin errors++; $display("FAIL to_next_issue: got we=%b wd=%h expected 1 55", writeEnable, writeData); end
    tick();
    tick();
    checks++; if ({done, err} !== 4'b0010) begin errors++; $display("FAIL to_next_done: got %b expected 0010", {done, err}); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    int spurious;
    ack_en = 1'b0;
    set_req(1, 1'b1, 4'd4, 32'h77);
    req = 3'b010;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    reset = 1'b1;
    req = 3'b000;
    tick();
    reset = 1'b0;
    ack_en = 1'b1;
    checks++; if ({busy, done, writeEnable} !== 5'b00000) begin errors++; $display("FAIL mid_reset: got %b expected 00000", {busy, done, writeEnable}); end
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done != 0 || busy) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", spurious); end
    rd_val = 32'h12345678;
    set_req(1, 1'b0, 4'd6, 32'h0);
    set_req(2, 1'b0, 4'd8, 32'h0);
    req = 3'b110;
    tick();
    checks++; if ({readEnable, address} !== {1'b1, 4'd6}) begin errors++; $display("FAIL mid_rr_zero: got en=%b addr=%h expected 1 6", readEnable, address); end
    tick();
    tick();
    checks++; if ({done, rdata} !== {3'b010, 32'h12345678}) begin errors++; $display("FAIL mid_done: got %b %h expected 010 12345678", done, rdata); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_admin();
    ack_en = 1'b1;
    set_req(0, 1'b1, 4'd2, 32'hA0);
    req = 3'b001;
    tick();
    checks++; if ({writeEnable, writeAdmin} !== {1'b1, EXP_ADM0}) begin errors++; $display("FAIL adm_r0: got we=%b adm=%b expected 1 %b", writeEnable, writeAdmin, EXP_ADM0); end
    tick();
    checks++; if (writeAdmin !== 1'b0) begin errors++; $display("FAIL adm_r0_pulse: got %b expected 0", writeAdmin); end
    tick();
    checks++; if (done !== 3'b001) begin errors++; $display("FAIL adm_r0_done: got %b expected 001", done); end
    req = 3'b000;
    tick();
    set_req(1, 1'b1, 4'd3, 32'hB1);
    req = 3'b010;
    tick();
    checks++; if ({writeEnable, writeAdmin, writeData} !== {1'b1, 1'b0, 32'hB1}) begin errors++; $display("FAIL adm_r1: got we=%b adm=%b wd=%h expected 1 0 b1", writeEnable, writeAdmin, writeData); end
    tick();
    tick();
    checks++; if (done !== 3'b010) begin errors++; $display("FAIL adm_r1_done: got %b expected 010", done); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_invariants();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", both_cnt); end
    checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL done_onehot: got %0d cycles expected 0", onehot_bad); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_ack();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_admin();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
